// File: rtl/csr_pkg.sv
// Shared CSR addresses, operation encoding and field layouts for the M-mode CSR unit.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MTVAL         = 12'h343;
  localparam logic [11:0] CSR_MIP           = 12'h344;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;
  localparam logic [11:0] CSR_MIMPID        = 12'hF13;
  localparam logic [11:0] CSR_MHARTID       = 12'hF14;

  // RV32I, MXL=1
  localparam logic [31:0] MISA_VAL = 32'h4000_0100;

  localparam logic [4:0] IRQ_CODE_MEI = 5'd11;
  localparam logic [4:0] IRQ_CODE_MTI = 5'd7;
  localparam logic [4:0] IRQ_CODE_MSI = 5'd3;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_t;

  typedef struct packed {
    logic        irq;
    logic [30:0] code;
  } mcause_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TRAP = 1'b1
  } trap_state_t;

  function automatic logic [31:0] csr_rmw(input csr_op_t op, input logic [31:0] old_v,
                                          input logic [31:0] wd);
    case (op)
      CSR_RW:  return wd;
      CSR_RS:  return old_v | wd;
      CSR_RC:  return old_v & ~wd;
      default: return old_v;
    endcase
  endfunction

  // {ext, timer, soft} placed at the MEI/MTI/MSI bit positions of mie/mip
  function automatic logic [31:0] irq_bits(input logic [2:0] v);
    return {20'b0, v[2], 3'b0, v[1], 3'b0, v[0], 3'b0};
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit event counter with inhibit and independently writable 32-bit halves.
module csr_counter64
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        inc_i,
  input  logic        inhibit_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] cnt_o
);

  logic [63:0] cnt_q, cnt_d;

  // Any software write to either half suppresses this cycle's increment.
  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) cnt_d[31:0]  = wdata_i;
      if (wr_hi_i) cnt_d[63:32] = wdata_i;
    end else if (inc_i && !inhibit_i) begin
      cnt_d = cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/csr_machine_unit.sv
// M-mode CSR file and trap controller: Zicsr ops, exceptions, interrupts, mret, counters.
//  state   | meaning
//  IDLE    | normal operation, interrupts may be taken
//  TRAP    | trap committed last edge; interrupts held off one cycle
module csr_machine_unit
  import csr_pkg::*;
#(
  parameter int          XLEN        = 32,
  parameter int          HART_ID     = 0,
  parameter logic [31:0] RESET_MTVEC = 32'h0,
  parameter bit          VECTORED_EN = 1'b1,
  parameter int          IRQ_SYNC    = 2
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            csr_req,
  input  logic [1:0]      csr_op,
  input  logic            csr_we,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            inst_retire,
  input  logic            exc_valid,
  input  logic [4:0]      exc_code,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_soft,
  output logic            trap_take,
  output logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] mepc_out
);

  trap_state_t state_q, state_d;

  logic            st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
  logic [2:0]      mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mtval_q, mtval_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  mcause_t         mcause_q, mcause_d;
  logic [1:0]      mcinh_q, mcinh_d;   // {IR, CY}

  logic [2:0]      sync_q [IRQ_SYNC];
  logic [2:0]      mip_w, pend_vec;
  logic [63:0]     mcycle_w, minstret_w;

  logic [XLEN-1:0] rd_val, wval, base;
  logic            impl, wr_ok, irq_allow, irq_pend, is_irq;
  logic [4:0]      irq_code, trap_code;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < IRQ_SYNC; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {irq_ext, irq_timer, irq_soft};
      for (int i = 1; i < IRQ_SYNC; i++) sync_q[i] <= sync_q[i-1];
    end
  end
  assign mip_w = sync_q[IRQ_SYNC-1];

  always_comb begin
    rd_val = '0;
    impl   = 1'b1;
    case (csr_addr)
      CSR_MSTATUS:       rd_val = {19'b0, 2'b11, 3'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0};
      CSR_MISA:          rd_val = MISA_VAL;
      CSR_MIE:           rd_val = irq_bits(mie_q);
      CSR_MTVEC:         rd_val = mtvec_q;
      CSR_MCOUNTINHIBIT: rd_val = {29'b0, mcinh_q[1], 1'b0, mcinh_q[0]};
      CSR_MSCRATCH:      rd_val = mscratch_q;
      CSR_MEPC:          rd_val = mepc_q;
      CSR_MCAUSE:        rd_val = mcause_q;
      CSR_MTVAL:         rd_val = mtval_q;
      CSR_MIP:           rd_val = irq_bits(mip_w);
      CSR_MCYCLE:        rd_val = mcycle_w[31:0];
      CSR_MCYCLEH:       rd_val = mcycle_w[63:32];
      CSR_MINSTRET:      rd_val = minstret_w[31:0];
      CSR_MINSTRETH:     rd_val = minstret_w[63:32];
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: rd_val = '0;
      CSR_MHARTID:       rd_val = XLEN'(HART_ID);
      default:           impl   = 1'b0;
    endcase
  end

  assign csr_rdata   = csr_req ? rd_val : '0;
  assign csr_illegal = csr_req & (!impl | (csr_we & (csr_addr[11:10] == 2'b11)));
  assign wval        = csr_rmw(csr_op_t'(csr_op), rd_val, csr_wdata);
  assign wr_ok       = csr_req & csr_we & (csr_op != CSR_NONE) & !csr_illegal & !trap_take;

  // Trap FSM: state register / next state / outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IDLE;
    if (trap_take) state_d = ST_TRAP;
  end

  always_comb begin
    irq_allow = (state_q == ST_IDLE);
  end

  assign pend_vec  = mie_q & mip_w;
  assign irq_pend  = irq_allow & st_mie_q & (|pend_vec);
  assign irq_code  = pend_vec[2] ? IRQ_CODE_MEI : (pend_vec[0] ? IRQ_CODE_MSI : IRQ_CODE_MTI);
  assign trap_take = exc_valid | (irq_pend & !mret);
  assign is_irq    = !exc_valid;
  assign trap_code = exc_valid ? exc_code : irq_code;
  assign base      = {mtvec_q[XLEN-1:2], 2'b00};

  always_comb begin
    trap_vector = '0;
    if (trap_take) begin
      if (is_irq && (mtvec_q[1:0] == 2'b01)) trap_vector = base + XLEN'({trap_code, 2'b00});
      else                                   trap_vector = base;
    end
  end

  assign mepc_out = mepc_q;

  always_comb begin
    st_mie_d   = st_mie_q;
    st_mpie_d  = st_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mscratch_d = mscratch_q;
    mcinh_d    = mcinh_q;
    if (trap_take) begin
      mepc_d        = exc_pc & ~XLEN'(3);
      mcause_d.irq  = is_irq;
      mcause_d.code = {26'b0, trap_code};
      mtval_d       = is_irq ? '0 : exc_tval;
      st_mpie_d     = st_mie_q;
      st_mie_d      = 1'b0;
    end else begin
      if (wr_ok) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            st_mie_d  = wval[3];
            st_mpie_d = wval[7];
          end
          CSR_MIE:           mie_d = {wval[11], wval[7], wval[3]};
          CSR_MTVEC: begin
            mtvec_d = {wval[XLEN-1:2], mtvec_q[1:0]};
            if (wval[1:0] == 2'b00 || (wval[1:0] == 2'b01 && VECTORED_EN))
              mtvec_d[1:0] = wval[1:0];
          end
          CSR_MCOUNTINHIBIT: mcinh_d    = {wval[2], wval[0]};
          CSR_MSCRATCH:      mscratch_d = wval;
          CSR_MEPC:          mepc_d     = wval & ~XLEN'(3);
          CSR_MCAUSE:        mcause_d   = mcause_t'(wval);
          CSR_MTVAL:         mtval_d    = wval;
          default: ;
        endcase
      end
      // mret overrides a same-cycle mstatus write
      if (mret) begin
        st_mie_d  = st_mpie_q;
        st_mpie_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      st_mie_q   <= 1'b0;
      st_mpie_q  <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= RESET_MTVEC;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mscratch_q <= '0;
      mcinh_q    <= '0;
    end else begin
      st_mie_q   <= st_mie_d;
      st_mpie_q  <= st_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mscratch_q <= mscratch_d;
      mcinh_q    <= mcinh_d;
    end
  end

  csr_counter64 u_mcycle (
    .clk       (clk),
    .nrst      (nrst),
    .inc_i     (1'b1),
    .inhibit_i (mcinh_q[0]),
    .wr_lo_i   (wr_ok && csr_addr == CSR_MCYCLE),
    .wr_hi_i   (wr_ok && csr_addr == CSR_MCYCLEH),
    .wdata_i   (wval),
    .cnt_o     (mcycle_w)
  );

  csr_counter64 u_minstret (
    .clk       (clk),
    .nrst      (nrst),
    .inc_i     (inst_retire),
    .inhibit_i (mcinh_q[1]),
    .wr_lo_i   (wr_ok && csr_addr == CSR_MINSTRET),
    .wr_hi_i   (wr_ok && csr_addr == CSR_MINSTRETH),
    .wdata_i   (wval),
    .cnt_o     (minstret_w)
  );

endmodule
